alloc: RTL and testbench

ALLOC -- requirements
Module: alloc

---
 rtl/alloc_pkg.sv | 57 +++++
 rtl/alloc_credit_ctr.sv | 41 ++++
 rtl/alloc.sv | 106 ++++++++++
 tb/tb_alloc.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alloc_pkg.sv
// Shared uop/rename packet types, RS target selection and alloc sizing constants.
// Pure declarations: no state, no latency, no flow control.
package alloc_pkg;

    localparam int ROBID_W        = 6;
    localparam int PREG_W         = 7;
    localparam int SIMID_W        = 16;
    localparam int ALLOC_NUM_RS   = 3;
    localparam int ALLOC_RS_DEPTH = 8;

    typedef enum logic [3:0] {
        UOP_NOP = 4'd0,
        UOP_ADD = 4'd1,
        UOP_SUB = 4'd2,
        UOP_AND = 4'd3,
        UOP_LD  = 4'd4,
        UOP_ST  = 4'd5,
        UOP_MUL = 4'd6,
        UOP_DIV = 4'd7
    } t_uop;

    typedef enum logic [1:0] {
        RS_ALU    = 2'd0,
        RS_MEM    = 2'd1,
        RS_MULDIV = 2'd2
    } t_rs_sel;

    typedef struct packed {
        logic               valid;
        logic [ROBID_W-1:0] robid;
    } t_nuke_pkt;

    typedef struct packed {
        logic [SIMID_W-1:0] SIMID;
        t_uop               uop;
        logic [15:0]        imm;
    } t_uinstr;

    typedef struct packed {
        logic [ROBID_W-1:0] robid;
        logic [PREG_W-1:0]  pdst;
        logic [PREG_W-1:0]  pdst_old;
        logic [PREG_W-1:0]  psrc1;
        logic [PREG_W-1:0]  psrc2;
        logic               psrc1_pend;
        logic               psrc2_pend;
    } t_rename_pkt;

    function automatic t_rs_sel f_alloc_target(input t_uinstr u);
        case (u.uop)
            UOP_LD, UOP_ST:   return RS_MEM;
            UOP_MUL, UOP_DIV: return RS_MULDIV;
            default:          return RS_ALU;
        endcase
    endfunction

endpackage

// File: rtl/alloc_credit_ctr.sv
// Per-RS credit counter: saturating at 0 and DEPTH, reload-to-full on flush; 1-cycle update.
// No flow control of its own; err pulses on a dropped increment or decrement.
module alloc_credit_ctr #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    input  logic          reload,
    output logic [CW-1:0] count,
    output logic          zero,
    output logic          full,
    output logic          err
);

    logic [CW-1:0] r_count;
    logic          w_up;
    logic          w_dn;

    assign zero  = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;

    // A simultaneous inc and dec cancels, so it can never be an error.
    assign w_up = inc & ~dec & ~full;
    assign w_dn = dec & ~inc & ~zero;
    assign err  = ~reload & ((inc & ~dec & full) | (dec & ~inc & zero));

    always_ff @(posedge clk) begin
        if (reset || reload) begin
            r_count <= CW'(DEPTH);
        end else if (w_up) begin
            r_count <= r_count + 1'b1;
        end else if (w_dn) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/alloc.sv
// Credit-gated in-order dispatch of renamed uops to one of NUM_RS reservation stations.
// Latency 1 (rn1 -> ra1); alloc_ready_ra0 drops when the target RS has no credit or on nuke.
module alloc
    import alloc_pkg::*;
#(
    parameter int NUM_RS   = ALLOC_NUM_RS,
    parameter int RS_DEPTH = ALLOC_RS_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  t_nuke_pkt         nuke_rb1,
    input  logic              valid_rn1,
    input  t_uinstr           uinstr_rn1,
    input  t_rename_pkt       rename_rn1,
    output logic              alloc_ready_ra0,
    input  logic [NUM_RS-1:0] rs_credit_ret_rsx,
    output logic [NUM_RS-1:0] valid_ra1,
    output t_uinstr           uinstr_ra1,
    output t_rename_pkt       rename_ra1,
    output logic              rs_empty_ra0,
    output logic              credit_err
);

    localparam int CW = $clog2(RS_DEPTH + 1);

    t_rs_sel           w_tgt;
    logic [NUM_RS-1:0] w_tgt_oh;
    logic [NUM_RS-1:0] w_dec;
    logic [NUM_RS-1:0] w_zero;
    logic [NUM_RS-1:0] w_full;
    logic [NUM_RS-1:0] w_err;
    logic [CW-1:0]     w_count [NUM_RS];
    logic              w_acc;

    logic [NUM_RS-1:0] r_valid;
    t_uinstr           r_uinstr;
    t_rename_pkt       r_rename;
    logic              r_err;

    logic w_unused_ok;
    assign w_unused_ok = ^nuke_rb1.robid;

    assign w_tgt = f_alloc_target(uinstr_rn1);

    always_comb begin
        w_tgt_oh = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            w_tgt_oh[i] = (int'(w_tgt) == i);
        end
    end

    // Ready looks only at the current counters: a return this cycle helps next cycle.
    assign alloc_ready_ra0 = ~nuke_rb1.valid & |(w_tgt_oh & ~w_zero);
    assign w_acc           = valid_rn1 & alloc_ready_ra0;
    assign w_dec           = w_acc ? w_tgt_oh : '0;

    for (genvar g = 0; g < NUM_RS; g++) begin : g_ctr
        alloc_credit_ctr #(
            .DEPTH (RS_DEPTH),
            .CW    (CW)
        ) u_ctr (
            .clk    (clk),
            .reset  (reset),
            .inc    (rs_credit_ret_rsx[g]),
            .dec    (w_dec[g]),
            .reload (nuke_rb1.valid),
            .count  (w_count[g]),
            .zero   (w_zero[g]),
            .full   (w_full[g]),
            .err    (w_err[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= '0;
            r_uinstr <= '0;
            r_rename <= '0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= w_dec;
            if (w_acc) begin
                r_uinstr <= uinstr_rn1;
                r_rename <= rename_rn1;
            end
            r_err <= r_err | (|w_err);
        end
    end

    assign valid_ra1    = r_valid;
    assign uinstr_ra1   = r_uinstr;
    assign rename_ra1   = r_rename;
    assign credit_err   = r_err;
    assign rs_empty_ra0 = &w_full;

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (!reset && w_acc) begin
            $display("UINFO %0d unit:AL target=%s robid=%0d credit=%0d",
                     uinstr_rn1.SIMID, w_tgt.name(), rename_rn1.robid,
                     w_count[w_tgt] - 1'b1);
        end
    end
`endif

endmodule

// File: tb/tb_alloc.sv
// Directed table-driven bench for alloc: one row per cycle plus reset/stall corner sequences.
module tb_alloc;
    import alloc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    t_nuke_pkt   nuke_rb1;
    logic        valid_rn1;
    t_uinstr     uinstr_rn1;
    t_rename_pkt rename_rn1;
    logic        alloc_ready_ra0;
    logic [2:0]  rs_credit_ret_rsx;
    logic [2:0]  valid_ra1;
    t_uinstr     uinstr_ra1;
    t_rename_pkt rename_ra1;
    logic        rs_empty_ra0;
    logic        credit_err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alloc dut (
        .clk               (clk),
        .reset             (reset),
        .nuke_rb1          (nuke_rb1),
        .valid_rn1         (valid_rn1),
        .uinstr_rn1        (uinstr_rn1),
        .rename_rn1        (rename_rn1),
        .alloc_ready_ra0   (alloc_ready_ra0),
        .rs_credit_ret_rsx (rs_credit_ret_rsx),
        .valid_ra1         (valid_ra1),
        .uinstr_ra1        (uinstr_ra1),
        .rename_ra1        (rename_ra1),
        .rs_empty_ra0      (rs_empty_ra0),
        .credit_err        (credit_err)
    );

    typedef struct {
        logic       nuke;
        logic       vld;
        t_uop       uop;
        logic [5:0] robid;
        logic [2:0] ret;
        logic       exp_rdy;
        logic [2:0] exp_vld;
        logic       exp_err;
        logic       exp_empty;
        logic [3:0] exp_a;
        logic [3:0] exp_m;
        logic [3:0] exp_d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic nuke, input logic vld, input t_uop uop,
                                input logic [5:0] robid, input logic [2:0] ret,
                                input logic rdy, input logic [2:0] ovld, input logic err,
                                input logic empty, input logic [3:0] a,
                                input logic [3:0] m, input logic [3:0] d);
        vec_t v;
        v.nuke = nuke; v.vld = vld; v.uop = uop; v.robid = robid; v.ret = ret;
        v.exp_rdy = rdy; v.exp_vld = ovld; v.exp_err = err; v.exp_empty = empty;
        v.exp_a = a; v.exp_m = m; v.exp_d = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic nuke, input logic vld, input t_uop uop,
                         input logic [5:0] robid, input logic [2:0] ret);
        nuke_rb1             = '0;
        nuke_rb1.valid       = nuke;
        valid_rn1            = vld;
        uinstr_rn1.SIMID     = {10'd0, robid};
        uinstr_rn1.uop       = uop;
        uinstr_rn1.imm       = 16'hBE00 | {10'd0, robid};
        rename_rn1           = '0;
        rename_rn1.robid     = robid;
        rename_rn1.pdst      = {1'b0, robid} ^ 7'h55;
        rename_rn1.psrc1_pend = robid[0];
        rs_credit_ret_rsx    = ret;
    endtask

    task automatic chk_payload(input string name, input logic [5:0] robid, input t_uop uop);
        chk({name, "_robid"}, 64'(rename_ra1.robid), 64'(robid));
        chk({name, "_pdst"},  64'(rename_ra1.pdst),  64'({1'b0, robid} ^ 7'h55));
        chk({name, "_uop"},   64'(uinstr_ra1.uop),   64'(uop));
    endtask

    initial begin
        // Build the main cycle-by-cycle vector table (credits A/M/D after each edge).
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 1, UOP_ADD, 6'(k + 1), 3'b000, 1, 3'b001, 0, 0, 4'(7 - k), 8, 8));
        tbl.push_back(mk(0, 1, UOP_ADD, 6'd9, 3'b000, 0, 3'b000, 0, 0, 0, 8, 8));
        tbl.push_back(mk(0, 1, UOP_ADD, 6'd9, 3'b001, 0, 3'b000, 0, 0, 1, 8, 8));
        tbl.push_back(mk(0, 1, UOP_ADD, 6'd9, 3'b000, 1, 3'b001, 0, 0, 0, 8, 8));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 1, UOP_LD, 6'(10 + k), 3'b000, 1, 3'b010, 0, 0, 0, 4'(7 - k), 8));
        tbl.push_back(mk(0, 1, UOP_ST, 6'd13, 3'b010, 1, 3'b010, 0, 0, 0, 5, 8));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(0, 1, UOP_MUL, 6'(14 + k), 3'b000, 1, 3'b100, 0, 0, 0, 5, 4'(7 - k)));
        tbl.push_back(mk(1, 1, UOP_MUL, 6'd20, 3'b001, 0, 3'b000, 0, 1, 8, 8, 8));
        tbl.push_back(mk(0, 0, UOP_ADD, 6'd0, 3'b100, 1, 3'b000, 1, 1, 8, 8, 8));
        tbl.push_back(mk(0, 0, UOP_ADD, 6'd0, 3'b000, 1, 3'b000, 1, 1, 8, 8, 8));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 1, UOP_DIV, 6'(21 + k), 3'b000, 1, 3'b100, 1, 0, 8, 8, 4'(7 - k)));
        tbl.push_back(mk(0, 1, UOP_ADD, 6'd29, 3'b000, 1, 3'b001, 1, 0, 7, 8, 0));
        tbl.push_back(mk(0, 1, UOP_LD,  6'd30, 3'b000, 1, 3'b010, 1, 0, 7, 7, 0));
        tbl.push_back(mk(0, 1, UOP_MUL, 6'd31, 3'b000, 0, 3'b000, 1, 0, 7, 7, 0));
        tbl.push_back(mk(0, 1, UOP_MUL, 6'd31, 3'b000, 0, 3'b000, 1, 0, 7, 7, 0));
        tbl.push_back(mk(0, 1, UOP_MUL, 6'd31, 3'b100, 0, 3'b000, 1, 0, 7, 7, 1));
        tbl.push_back(mk(0, 1, UOP_MUL, 6'd31, 3'b000, 1, 3'b100, 1, 0, 7, 7, 0));
        tbl.push_back(mk(0, 1, UOP_ADD, 6'd32, 3'b000, 1, 3'b001, 1, 0, 6, 7, 0));

        // Reset state.
        reset = 1'b1;
        drive(0, 0, UOP_ADD, 6'd0, 3'b000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready",   64'(alloc_ready_ra0), 64'(1));
        chk("rst_valid",   64'(valid_ra1),       64'(0));
        chk("rst_err",     64'(credit_err),      64'(0));
        chk("rst_empty",   64'(rs_empty_ra0),    64'(1));
        chk("rst_rename",  64'(rename_ra1),      64'(0));
        chk("rst_uinstr",  64'(uinstr_ra1),      64'(0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].nuke, tbl[i].vld, tbl[i].uop, tbl[i].robid, tbl[i].ret);
            #1;
            chk($sformatf("row%0d_ready", i), 64'(alloc_ready_ra0), 64'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid", i), 64'(valid_ra1),      64'(tbl[i].exp_vld));
            chk($sformatf("row%0d_err", i),   64'(credit_err),     64'(tbl[i].exp_err));
            chk($sformatf("row%0d_empty", i), 64'(rs_empty_ra0),   64'(tbl[i].exp_empty));
            chk($sformatf("row%0d_cred_alu", i),    64'(dut.w_count[0]), 64'(tbl[i].exp_a));
            chk($sformatf("row%0d_cred_mem", i),    64'(dut.w_count[1]), 64'(tbl[i].exp_m));
            chk($sformatf("row%0d_cred_muldiv", i), 64'(dut.w_count[2]), 64'(tbl[i].exp_d));
            if (tbl[i].exp_vld != 3'b000)
                chk_payload($sformatf("row%0d", i), tbl[i].robid, tbl[i].uop);
        end

        // MULDIV starved: stalled uop, payload must hold the last accepted uop.
        @(negedge clk);
        drive(0, 1, UOP_MUL, 6'd33, 3'b000);
        #1;
        chk("stall_ready", 64'(alloc_ready_ra0), 64'(0));
        @(posedge clk);
        #1;
        chk("stall_valid", 64'(valid_ra1), 64'(0));
        chk_payload("hold", 6'd32, UOP_ADD);

        // Reset together with nuke, while the stalled uop is still presented.
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1, UOP_MUL, 6'd33, 3'b111);
        @(posedge clk);
        #1;
        chk("rstnuke_valid",  64'(valid_ra1),       64'(0));
        chk("rstnuke_err",    64'(credit_err),      64'(0));
        chk("rstnuke_empty",  64'(rs_empty_ra0),    64'(1));
        chk("rstnuke_rename", 64'(rename_ra1),      64'(0));
        chk("rstnuke_muldiv", 64'(dut.w_count[2]),  64'(8));

        // First cycle after reset: a fresh MULDIV uop is accepted immediately.
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1, UOP_DIV, 6'd1, 3'b000);
        #1;
        chk("post_rst_ready", 64'(alloc_ready_ra0), 64'(1));
        @(posedge clk);
        #1;
        chk("post_rst_valid", 64'(valid_ra1), 64'(3'b100));
        chk_payload("post_rst", 6'd1, UOP_DIV);
        chk("post_rst_muldiv", 64'(dut.w_count[2]), 64'(7));

        @(negedge clk);
        drive(0, 0, UOP_NOP, 6'd0, 3'b000);
        @(posedge clk);
        #1;
        chk("idle_valid", 64'(valid_ra1), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
